// File: rtl/wb_gpio_arb.sv
// wb_gpio_arb: two-master Wishbone arbiter in front of the 16-bit GPIO slave.
//   Round-robin at Wishbone-cycle granularity: a grant is held while the owner keeps cyc high.
//   Optional watchdog (define WB_GPIO_ARB_TIMEOUT_EN) terminates strobes the slave never acks
//   with ack = 1 and dat = 16'hFFFF.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_*_i / m0_*_o           master 0 (CPU bridge) request / response
//   m1_*_i / m1_*_o           master 1 (debug / POST-code) request / response
//   s_*_o / s_*_i             slave request / response (slave ack may be combinational)
//   gnt_o                     one-hot grant, bit0 = m0, bit1 = m1, 00 when idle
//   tout_o                    one-cycle pulse on watchdog termination
module wb_gpio_arb #(
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_adr_o,
    output logic [15:0] s_dat_o,
    output logic [1:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        tout_o
);

    typedef enum logic [1:0] {StIdle = 2'd0, StGnt0 = 2'd1, StGnt1 = 2'd2} state_e;

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;   // 0: m0 favoured on a tie, 1: m1 favoured
    logic [1:0] gnt_q, gnt_d;
    logic       wd_fire;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = ptr_q ? StGnt1 : StGnt0;
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    ptr_d   = 1'b1;
                    state_d = m1_cyc_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    ptr_d   = 1'b0;
                    state_d = m0_cyc_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        gnt_d = {state_d == StGnt1, state_d == StGnt0};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_o = gnt_q;

    // Slave request mux; everything reads 0 while idle.
    always_comb begin
        s_adr_o = 1'b0;
        s_dat_o = 16'h0000;
        s_sel_o = 2'b00;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (gnt_q[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
        end else if (gnt_q[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
        end
    end

`ifdef WB_GPIO_ARB_TIMEOUT_EN
    // Fire when this unacked strobe would bring the count to all-ones, so the ack lands
    // on the (2^TIMEOUT_W-1)-th unacked strobe cycle.
    localparam logic [TIMEOUT_W-1:0] CntFire = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] CntOne  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    assign wd_fire = s_stb_o && !s_ack_i && (cnt_q == CntFire);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle || state_d != state_q || s_ack_i || wd_fire) begin
            cnt_d = '0;
        end else if (s_stb_o) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tout_o = wd_fire && !wb_rst_i;
`else
    assign wd_fire = 1'b0;
    assign tout_o  = 1'b0;
`endif

    // No ack may escape during the reset cycle.
    assign m0_ack_o = !wb_rst_i && gnt_q[0] && (s_ack_i || wd_fire);
    assign m1_ack_o = !wb_rst_i && gnt_q[1] && (s_ack_i || wd_fire);
    assign m0_dat_o = (wd_fire && gnt_q[0]) ? 16'hFFFF : s_dat_i;
    assign m1_dat_o = (wd_fire && gnt_q[1]) ? 16'hFFFF : s_dat_i;

endmodule

// File: tb/tb_wb_gpio_arb.sv
module tb_wb_gpio_arb;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_adr_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o;
    logic [15:0] m0_dat_i, m0_dat_o;
    logic [1:0]  m0_sel_i;
    logic        m1_adr_i, m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o;
    logic [15:0] m1_dat_i, m1_dat_o;
    logic [1:0]  m1_sel_i;
    logic        s_adr_o, s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [15:0] s_dat_o, s_dat_i;
    logic [1:0]  s_sel_o, gnt_o;
    logic        tout_o;
    logic        ack_en;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    // Combinational-ack slave returning a fixed read word.
    assign s_ack_i = s_stb_o & ack_en;
    assign s_dat_i = 16'h1234;

    wb_gpio_arb #(.TIMEOUT_W(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .tout_o(tout_o)
    );

    // m0c/m1c = {cyc, stb, we, adr}; sc = expected {s_cyc, s_stb, s_we, s_adr};
    // ack = expected {m0_ack, m1_ack}.
    typedef struct packed {
        logic [3:0]  m0c;
        logic [15:0] m0d;
        logic [3:0]  m1c;
        logic [15:0] m1d;
        logic        en;
        logic [1:0]  gnt;
        logic [3:0]  sc;
        logic [15:0] sd;
        logic [1:0]  ack;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive_m0(input logic [3:0] c, input logic [15:0] d);
        {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i} = c;
        m0_dat_i = d;
    endtask

    task automatic drive_m1(input logic [3:0] c, input logic [15:0] d);
        {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i} = c;
        m1_dat_i = d;
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic step();
        @(negedge wb_clk_i);
    endtask

    task automatic do_reset();
        step();
        drive_m0(4'b0000, 16'h0);
        drive_m1(4'b0000, 16'h0);
        ack_en   = 1'b1;
        wb_rst_i = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        int m0_left, m1_left, ngr, ack_cyc, tcnt, stb_cnt;
        logic m0_drop, m1_drop;
        logic [1:0] last_gnt;
        logic [1:0] seen[6];
        logic [1:0] rr_exp[6];
        logic [15:0] fire_dat;

        m0_sel_i = 2'b01;
        m1_sel_i = 2'b10;
        vecs[0]  = '{4'b1100, 16'h0000, 4'b0000, 16'h0000, 1'b1, 2'b00, 4'b0000, 16'h0000, 2'b00};
        vecs[1]  = '{4'b1100, 16'h0000, 4'b0000, 16'h0000, 1'b1, 2'b01, 4'b1100, 16'h0000, 2'b10};
        vecs[2]  = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 1'b1, 2'b01, 4'b0000, 16'h0000, 2'b00};
        vecs[3]  = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 1'b1, 2'b00, 4'b0000, 16'h0000, 2'b00};
        vecs[4]  = '{4'b1111, 16'h00A5, 4'b1110, 16'h5A00, 1'b1, 2'b00, 4'b0000, 16'h0000, 2'b00};
        vecs[5]  = '{4'b1111, 16'h00A5, 4'b1110, 16'h5A00, 1'b1, 2'b10, 4'b1110, 16'h5A00, 2'b01};
        vecs[6]  = '{4'b1111, 16'h00A5, 4'b0000, 16'h0000, 1'b1, 2'b10, 4'b0000, 16'h0000, 2'b00};
        vecs[7]  = '{4'b1111, 16'h00A5, 4'b1110, 16'h5A00, 1'b1, 2'b01, 4'b1111, 16'h00A5, 2'b10};
        vecs[8]  = '{4'b1111, 16'h00A5, 4'b1110, 16'h5A00, 1'b0, 2'b01, 4'b1111, 16'h00A5, 2'b00};
        vecs[9]  = '{4'b0000, 16'h0000, 4'b1110, 16'h5A00, 1'b1, 2'b01, 4'b0000, 16'h0000, 2'b00};
        vecs[10] = '{4'b0000, 16'h0000, 4'b1110, 16'h5A00, 1'b1, 2'b10, 4'b1110, 16'h5A00, 2'b01};
        vecs[11] = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 1'b1, 2'b10, 4'b0000, 16'h0000, 2'b00};
        vecs[12] = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 1'b1, 2'b00, 4'b0000, 16'h0000, 2'b00};
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        // Reset state
        do_reset();
        #1;
        check("reset_gnt", 32'(gnt_o), 32'h0);
        check("reset_tout", 32'(tout_o), 32'h0);
        check("reset_slave_req", 32'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}),
              32'h0);

        // Simultaneous request from reset: m0 first, m1 on the very next cycle
        step(); drive_m0(4'b1111, 16'h00A5); drive_m1(4'b1110, 16'h5A00); #1;
        check("both_req_wait_gnt", 32'(gnt_o), 32'h0);
        step(); #1;
        check("both_req_gnt_m0", 32'(gnt_o), 32'h1);
        check("m0_write_data", 32'({s_dat_o, s_sel_o, s_adr_o, s_we_o}),
              32'({16'h00A5, 2'b01, 1'b1, 1'b1}));
        check("m0_write_ack", 32'({m0_ack_o, m1_ack_o}), 32'h2);
        step(); drive_m0(4'b0000, 16'h0); #1;
        check("m0_release_scyc", 32'(s_cyc_o), 32'h0);
        step(); #1;
        check("handover_gnt_m1", 32'(gnt_o), 32'h2);
        check("m1_write_data", 32'({s_dat_o, s_sel_o, s_adr_o, s_we_o}),
              32'({16'h5A00, 2'b10, 1'b0, 1'b1}));
        check("m1_write_ack", 32'({m0_ack_o, m1_ack_o}), 32'h1);
        step(); drive_m1(4'b0000, 16'h0);

        // Single m0 read with combinational slave ack
        do_reset();
        step(); drive_m0(4'b1100, 16'h0); #1;
        check("read_scyc_lat0", 32'(s_cyc_o), 32'h0);
        step(); #1;
        check("read_scyc_lat1", 32'(s_cyc_o), 32'h1);
        check("read_ack_dat", 32'({m0_ack_o, m1_ack_o, m0_dat_o}), 32'({2'b10, 16'h1234}));
        step(); drive_m0(4'b0000, 16'h0);

        // Table-driven sequence
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step();
            drive_m0(vecs[i].m0c, vecs[i].m0d);
            drive_m1(vecs[i].m1c, vecs[i].m1d);
            ack_en = vecs[i].en;
            #1;
            check($sformatf("vec%0d", i),
                  32'({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o}),
                  32'({vecs[i].gnt, vecs[i].sc, vecs[i].sd, vecs[i].ack}));
        end

        // Round-robin: each master does 3 single-beat cycles, idling one cycle between them
        do_reset();
        m0_left = 3; m1_left = 3; m0_drop = 1'b0; m1_drop = 1'b0;
        ngr = 0; last_gnt = 2'b00;
        for (int c = 0; c < 40 && (m0_left > 0 || m1_left > 0); c++) begin
            step();
            drive_m0((m0_left > 0 && !m0_drop) ? 4'b1100 : 4'b0000, 16'h0);
            drive_m1((m1_left > 0 && !m1_drop) ? 4'b1100 : 4'b0000, 16'h0);
            m0_drop = 1'b0; m1_drop = 1'b0;
            #1;
            if (gnt_o != 2'b00 && gnt_o != last_gnt && ngr < 6) begin
                seen[ngr] = gnt_o;
                ngr++;
            end
            last_gnt = gnt_o;
            if (m0_ack_o) begin m0_left--; m0_drop = 1'b1; end
            if (m1_ack_o) begin m1_left--; m1_drop = 1'b1; end
        end
        check("rr_grant_count", 32'(ngr), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ngr) check($sformatf("rr_grant%0d", i), 32'(seen[i]), 32'(rr_exp[i]));
        end
        step(); drive_m0(4'b0000, 16'h0); drive_m1(4'b0000, 16'h0);

        // Reset while GNT1 with stb high; pointer must return to m0
        do_reset();
        step(); drive_m0(4'b1100, 16'h0); #1;
        step(); #1;
        step(); drive_m0(4'b0000, 16'h0); #1;   // m0 releases: pointer now favours m1
        step(); drive_m1(4'b1100, 16'h0); ack_en = 1'b0; #1;
        step(); #1;
        check("pre_reset_gnt_m1", 32'(gnt_o), 32'h2);
        step(); wb_rst_i = 1'b1; ack_en = 1'b1; #1;
        check("reset_cycle_no_ack", 32'({m0_ack_o, m1_ack_o}), 32'h0);
        step(); wb_rst_i = 1'b0; drive_m0(4'b1100, 16'h0); #1;
        check("post_reset_idle", 32'({gnt_o, s_cyc_o, s_stb_o, m1_ack_o}), 32'h0);
        step(); #1;
        check("post_reset_tie_m0", 32'(gnt_o), 32'h1);
        step(); drive_m0(4'b0000, 16'h0); drive_m1(4'b0000, 16'h0);

        // Unacked strobe: watchdog if built in, otherwise an indefinite stall
        do_reset();
        step(); drive_m0(4'b1100, 16'h0); ack_en = 1'b0;
        ack_cyc = 0; tcnt = 0; stb_cnt = 0; fire_dat = 16'h0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            #1;
            if (s_stb_o) stb_cnt++;
            if (tout_o) tcnt++;
            if (m0_ack_o && ack_cyc == 0) begin
                ack_cyc  = stb_cnt;
                fire_dat = m0_dat_o;
            end
        end
`ifdef WB_GPIO_ARB_TIMEOUT_EN
        check("wd_ack_cycle", 32'(ack_cyc), 32'd15);
        check("wd_ack_dat", 32'(fire_dat), 32'hFFFF);
        check("wd_tout_pulses", 32'(tcnt), 32'd1);
`else
        check("stall_no_ack", 32'(ack_cyc), 32'd0);
        check("stall_no_tout", 32'(tcnt), 32'd0);
        check("stall_still_granted", 32'(gnt_o), 32'h1);
`endif
        step(); drive_m0(4'b0000, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
